// File: rtl/camo_pkg.sv
// Shared types and mask helpers for the key-recovery harness blocks.
package camo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        QUERY,
        DRIVE,
        CHECK,
        NEXT,
        FIN
    } state_t;

    localparam int KEY_W_DEF = 2;
    localparam int NKEYS     = 2 ** KEY_W_DEF;

    // Widest candidate mask the helpers accept (KEY_W up to 6).
    localparam int MASK_MAX  = 64;

    function automatic int popcount(input logic [MASK_MAX-1:0] m);
        int c;
        c = 0;
        for (int i = 0; i < MASK_MAX; i++) begin
            c = c + int'(m[i]);
        end
        return c;
    endfunction

    function automatic int lowest_set(input logic [MASK_MAX-1:0] m);
        int idx;
        idx = 0;
        for (int i = MASK_MAX - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/camo_mask_eval.sv
// Summarises a one-hot candidate mask: unique survivor, its index, or conflict.
module camo_mask_eval
    import camo_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic [2**KEY_W-1:0] mask,
    output logic                key_unique,
    output logic [KEY_W-1:0]    key_value,
    output logic                conflict
);

    logic [MASK_MAX-1:0] wide;

    assign wide       = MASK_MAX'(mask);
    assign key_unique = (popcount(wide) == 1);
    assign key_value  = KEY_W'(lowest_set(wide));
    assign conflict   = ~|mask;

endmodule

// File: rtl/camo_key_resolver.sv
// Oracle-guided key pruning over every input pattern of a locked netlist.
// Define CAMO_EARLY_EXIT_EN to stop once at most one candidate survives.
module camo_key_resolver
    import camo_pkg::*;
#(
    parameter int PI_W  = 5,
    parameter int PO_W  = 2,
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                orc_req,
    output logic [PI_W-1:0]     orc_pi,
    input  logic                orc_ack,
    input  logic [PO_W-1:0]     orc_po,
    output logic [PI_W-1:0]     lk_pi,
    output logic [KEY_W-1:0]    lk_key,
    input  logic [PO_W-1:0]     lk_po,
    output logic [2**KEY_W-1:0] key_mask,
    output logic                key_unique,
    output logic [KEY_W-1:0]    key_value,
    output logic                conflict
);

    localparam int NK = 2 ** KEY_W;
    localparam int NP = 2 ** PI_W;
    localparam logic [PI_W:0]  P_LAST = (PI_W+1)'(NP - 1);
    localparam logic [KEY_W:0] K_LAST = (KEY_W+1)'(NK - 1);

    state_t            state, state_n;
    logic [PI_W:0]     p, p_n;
    logic [KEY_W:0]    k, k_n;
    logic [NK-1:0]     mask, mask_n;
    logic [PO_W-1:0]   golden, golden_n;
    logic [PI_W-1:0]   lk_pi_n;
    logic [KEY_W-1:0]  lk_key_n;
    logic [KEY_W-1:0]  kidx;
    logic              ev_unique;
    logic [KEY_W-1:0]  ev_value;
    logic              ev_conflict;

    assign kidx     = k[KEY_W-1:0];
    assign busy     = (state != IDLE);
    assign orc_req  = (state == QUERY);
    assign orc_pi   = p[PI_W-1:0];
    assign key_mask = mask;

    camo_mask_eval #(
        .KEY_W (KEY_W)
    ) u_eval (
        .mask       (mask),
        .key_unique (ev_unique),
        .key_value  (ev_value),
        .conflict   (ev_conflict)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            p          <= '0;
            k          <= '0;
            mask       <= '1;
            golden     <= '0;
            lk_pi      <= '0;
            lk_key     <= '0;
            done       <= 1'b0;
            key_unique <= 1'b0;
            key_value  <= '0;
            conflict   <= 1'b0;
        end else begin
            state  <= state_n;
            p      <= p_n;
            k      <= k_n;
            mask   <= mask_n;
            golden <= golden_n;
            lk_pi  <= lk_pi_n;
            lk_key <= lk_key_n;
            done   <= (state == FIN);
            if (state == FIN) begin
                key_unique <= ev_unique;
                key_value  <= ev_value;
                conflict   <= ev_conflict;
            end
        end
    end

    always_comb begin
        state_n  = state;
        p_n      = p;
        k_n      = k;
        mask_n   = mask;
        golden_n = golden;
        lk_pi_n  = lk_pi;
        lk_key_n = lk_key;

        unique case (state)
            IDLE: begin
                if (start) begin
                    mask_n  = '1;
                    p_n     = '0;
                    state_n = QUERY;
                end
            end
            QUERY: begin
                if (orc_ack) begin
                    golden_n = orc_po;
                    k_n      = '0;
                    state_n  = DRIVE;
                end
            end
            DRIVE: begin
                // Pruned keys are skipped without touching the netlist.
                if (!mask[kidx]) begin
                    if (k == K_LAST) begin
                        state_n = NEXT;
                    end else begin
                        k_n = k + 1'b1;
                    end
                end else begin
                    lk_pi_n  = p[PI_W-1:0];
                    lk_key_n = kidx;
                    state_n  = CHECK;
                end
            end
            CHECK: begin
                if (lk_po != golden) begin
                    mask_n[kidx] = 1'b0;
                end
                if (k == K_LAST) begin
                    state_n = NEXT;
                end else begin
                    k_n     = k + 1'b1;
                    state_n = DRIVE;
                end
            end
            NEXT: begin
                if (p == P_LAST) begin
                    state_n = FIN;
`ifdef CAMO_EARLY_EXIT_EN
                end else if (popcount(MASK_MAX'(mask)) <= 1) begin
                    state_n = FIN;
`endif
                end else begin
                    p_n     = p + 1'b1;
                    state_n = QUERY;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
